// File: rtl/seg_time_pkg.sv
// Shared types, digit limits and preset field positions for the HH:MM:SS counter.
package seg_time_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] SEC_U_MAX     = 4'd9;
  localparam logic [3:0] SEC_T_MAX     = 4'd5;
  localparam logic [3:0] MIN_U_MAX     = 4'd9;
  localparam logic [3:0] MIN_T_MAX     = 4'd5;
  localparam logic [3:0] HR_U_MAX      = 4'd9;
  localparam logic [3:0] HR_MAX_T      = 4'd2;
  localparam logic [3:0] HR_MAX_U_AT_2 = 4'd3;

  localparam int unsigned SEC_U_LSB = 0;
  localparam int unsigned SEC_T_LSB = 4;
  localparam int unsigned MIN_U_LSB = 8;
  localparam int unsigned MIN_T_LSB = 12;
  localparam int unsigned HR_U_LSB  = 16;
  localparam int unsigned HR_T_LSB  = 20;

  function automatic logic load_legal(input logic [23:0] d);
    logic hr_ok;
    if (d[HR_T_LSB +: 4] < HR_MAX_T)
      hr_ok = (d[HR_U_LSB +: 4] <= HR_U_MAX);
    else if (d[HR_T_LSB +: 4] == HR_MAX_T)
      hr_ok = (d[HR_U_LSB +: 4] <= HR_MAX_U_AT_2);
    else
      hr_ok = 1'b0;
    return hr_ok
        && (d[SEC_U_LSB +: 4] <= SEC_U_MAX)
        && (d[SEC_T_LSB +: 4] <= SEC_T_MAX)
        && (d[MIN_U_LSB +: 4] <= MIN_U_MAX)
        && (d[MIN_T_LSB +: 4] <= MIN_T_MAX);
  endfunction

endpackage

// File: rtl/seg_time_counter_bcd_digit.sv
// One BCD digit with wrap at MAX; priority clear > load > increment.
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc && (q == MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (ld)
      q <= ld_val;
    else if (inc)
      q <= (q == MAX) ? 4'd0 : q + 4'd1;
  end

endmodule

// File: rtl/seg_time_counter.sv
// HH:MM:SS BCD time-of-day counter with 1 s prescaler, start/stop, clear and validated preset.
module seg_time_counter
  import seg_time_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clr,
  input  logic        load_valid,
  input  logic [23:0] load_data,
  output logic        load_ready,
  output logic        load_err,
  output logic [3:0]  seg0_dig,
  output logic [3:0]  seg1_dig,
  output logic [3:0]  seg2_dig,
  output logic [3:0]  seg3_dig,
  output logic [3:0]  seg4_dig,
  output logic [3:0]  seg5_dig,
  output logic        sec_pulse,
  output logic        rollover
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  state_t           state, state_nxt;
  logic [PRE_W-1:0] pre;
  logic             load_acc, load_ok, tick;
  logic             c0, c1, c2, c3, c4, hr_wrap;
  logic             hr_t_carry_unused;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= STOP;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STOP:    if (start && !stop) state_nxt = RUN;
      RUN:     if (stop && !start) state_nxt = STOP;
      default: state_nxt = STOP;
    endcase
  end

  assign load_ready = (state == STOP);
  assign load_acc   = load_valid && load_ready && !clr;
  assign load_ok    = load_acc && load_legal(load_data);
  assign tick       = (state == RUN) && (pre == PRE_MAX) && !clr && !load_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pre <= '0;
    else if (clr || load_ok)
      pre <= '0;
    else if (state == RUN)
      pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
  end

  // Hours wrap 23 -> 00 by clearing both hour digits instead of letting units count on.
  assign hr_wrap = c3 && (seg5_dig == HR_MAX_T) && (seg4_dig == HR_MAX_U_AT_2);

  bcd_digit #(.MAX(SEC_U_MAX)) u_sec_u (
    .clk(clk), .reset_n(reset_n), .inc(tick), .clr(clr), .ld(load_ok),
    .ld_val(load_data[SEC_U_LSB +: 4]), .q(seg0_dig), .carry(c0)
  );
  bcd_digit #(.MAX(SEC_T_MAX)) u_sec_t (
    .clk(clk), .reset_n(reset_n), .inc(c0), .clr(clr), .ld(load_ok),
    .ld_val(load_data[SEC_T_LSB +: 4]), .q(seg1_dig), .carry(c1)
  );
  bcd_digit #(.MAX(MIN_U_MAX)) u_min_u (
    .clk(clk), .reset_n(reset_n), .inc(c1), .clr(clr), .ld(load_ok),
    .ld_val(load_data[MIN_U_LSB +: 4]), .q(seg2_dig), .carry(c2)
  );
  bcd_digit #(.MAX(MIN_T_MAX)) u_min_t (
    .clk(clk), .reset_n(reset_n), .inc(c2), .clr(clr), .ld(load_ok),
    .ld_val(load_data[MIN_T_LSB +: 4]), .q(seg3_dig), .carry(c3)
  );
  bcd_digit #(.MAX(HR_U_MAX)) u_hr_u (
    .clk(clk), .reset_n(reset_n), .inc(c3 && !hr_wrap), .clr(clr || hr_wrap), .ld(load_ok),
    .ld_val(load_data[HR_U_LSB +: 4]), .q(seg4_dig), .carry(c4)
  );
  bcd_digit #(.MAX(HR_MAX_T)) u_hr_t (
    .clk(clk), .reset_n(reset_n), .inc(c4), .clr(clr || hr_wrap), .ld(load_ok),
    .ld_val(load_data[HR_T_LSB +: 4]), .q(seg5_dig), .carry(hr_t_carry_unused)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_pulse <= 1'b0;
      rollover  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_pulse <= tick;
      rollover  <= hr_wrap;
      load_err  <= load_acc && !load_ok;
    end
  end

endmodule

// File: tb/tb_seg_time_counter.sv
// Directed self-checking bench for seg_time_counter with TICK_DIV = 4.
module tb_seg_time_counter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clr = 1'b0, load_valid = 1'b0;
  logic [23:0] load_data = '0;
  logic        load_ready, load_err, sec_pulse, rollover;
  logic [3:0]  seg0_dig, seg1_dig, seg2_dig, seg3_dig, seg4_dig, seg5_dig;
  logic [23:0] digits;
  int          checks = 0;
  int          failures = 0;

  assign digits = {seg5_dig, seg4_dig, seg3_dig, seg2_dig, seg1_dig, seg0_dig};

  seg_time_counter #(.TICK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clr(clr),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_err(load_err), .seg0_dig(seg0_dig), .seg1_dig(seg1_dig),
    .seg2_dig(seg2_dig), .seg3_dig(seg3_dig), .seg4_dig(seg4_dig),
    .seg5_dig(seg5_dig), .sec_pulse(sec_pulse), .rollover(rollover)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (digits !== 24'h000000) begin failures++; $display("FAIL reset_digits got=%h exp=000000", digits); end
    checks++;
    if ({sec_pulse, rollover, load_err, load_ready} !== 4'b0001) begin
      failures++; $display("FAIL reset_flags got=%b exp=0001", {sec_pulse, rollover, load_err, load_ready});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_count();
    logic [23:0] exp;
    start = 1'b1; cyc(); start = 1'b0;
    for (int s = 1; s <= 10; s++) begin
      for (int k = 0; k < 3; k++) begin
        cyc();
        checks++;
        if (sec_pulse !== 1'b0) begin failures++; $display("FAIL count_quiet s=%0d got=%b exp=0", s, sec_pulse); end
      end
      cyc();
      exp = '0;
      exp[7:4] = 4'(s / 10);
      exp[3:0] = 4'(s % 10);
      checks++;
      if (sec_pulse !== 1'b1 || digits !== exp) begin
        failures++; $display("FAIL count_tick s=%0d got=%b/%h exp=1/%h", s, sec_pulse, digits, exp);
      end
    end
  endtask

  task automatic test_stop_resume();
    cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    checks++;
    if (load_ready !== 1'b1) begin failures++; $display("FAIL stop_state got=%b exp=1", load_ready); end
    for (int k = 0; k < 20; k++) begin
      cyc();
      checks++;
      if (digits !== 24'h000010 || sec_pulse !== 1'b0) begin
        failures++; $display("FAIL stopped_hold k=%0d got=%h/%b exp=000010/0", k, digits, sec_pulse);
      end
    end
    start = 1'b1; cyc(); start = 1'b0;
    checks++;
    if (load_ready !== 1'b0 || sec_pulse !== 1'b0) begin
      failures++; $display("FAIL resume_run got=%b/%b exp=0/0", load_ready, sec_pulse);
    end
    cyc();
    checks++;
    if (sec_pulse !== 1'b0) begin failures++; $display("FAIL resume_early got=%b exp=0", sec_pulse); end
    cyc();
    checks++;
    if (sec_pulse !== 1'b1 || digits !== 24'h000011) begin
      failures++; $display("FAIL resume_tick got=%b/%h exp=1/000011", sec_pulse, digits);
    end
  endtask

  task automatic test_load_in_run();
    load_valid = 1'b1; load_data = 24'h123456;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (load_ready !== 1'b0 || digits !== 24'h000011 || load_err !== 1'b0) begin
        failures++; $display("FAIL run_load_ignored k=%0d got=%b/%h/%b exp=0/000011/0", k, load_ready, digits, load_err);
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    checks++;
    if (sec_pulse !== 1'b1 || digits !== 24'h000012 || load_ready !== 1'b1) begin
      failures++; $display("FAIL stop_on_tick got=%b/%h/%b exp=1/000012/1", sec_pulse, digits, load_ready);
    end
    cyc();
    load_valid = 1'b0;
    checks++;
    if (digits !== 24'h123456 || load_err !== 1'b0 || sec_pulse !== 1'b0) begin
      failures++; $display("FAIL load_after_stop got=%h/%b/%b exp=123456/0/0", digits, load_err, sec_pulse);
    end
  endtask

  task automatic test_load_err();
    logic [23:0] bad [2];
    bad[0] = 24'h240000;
    bad[1] = 24'h006000;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = bad[i]; cyc(); load_valid = 1'b0;
      checks++;
      if (load_err !== 1'b1 || digits !== 24'h123456) begin
        failures++; $display("FAIL load_illegal data=%h got=%b/%h exp=1/123456", bad[i], load_err, digits);
      end
      cyc();
      checks++;
      if (load_err !== 1'b0) begin failures++; $display("FAIL load_err_pulse data=%h got=%b exp=0", bad[i], load_err); end
    end
  endtask

  task automatic test_rollover();
    load_valid = 1'b1; load_data = 24'h235959; cyc(); load_valid = 1'b0;
    checks++;
    if (digits !== 24'h235959) begin failures++; $display("FAIL load_235959 got=%h exp=235959", digits); end
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (sec_pulse !== 1'b0 || rollover !== 1'b0) begin
        failures++; $display("FAIL roll_early k=%0d got=%b/%b exp=0/0", k, sec_pulse, rollover);
      end
    end
    cyc();
    checks++;
    if (sec_pulse !== 1'b1 || rollover !== 1'b1 || digits !== 24'h000000) begin
      failures++; $display("FAIL rollover got=%b/%b/%h exp=1/1/000000", sec_pulse, rollover, digits);
    end
    cyc();
    checks++;
    if (sec_pulse !== 1'b0 || rollover !== 1'b0) begin
      failures++; $display("FAIL rollover_pulse got=%b/%b exp=0/0", sec_pulse, rollover);
    end
  endtask

  task automatic test_hour_carry();
    stop = 1'b1; cyc(); stop = 1'b0;
    load_valid = 1'b1; load_data = 24'h195959; cyc(); load_valid = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();
    cyc();
    checks++;
    if (sec_pulse !== 1'b1 || rollover !== 1'b0 || digits !== 24'h200000) begin
      failures++; $display("FAIL hour_carry got=%b/%b/%h exp=1/0/200000", sec_pulse, rollover, digits);
    end
  endtask

  task automatic test_clr_on_tick();
    repeat (3) cyc();
    clr = 1'b1; cyc(); clr = 1'b0;
    checks++;
    if (digits !== 24'h000000 || sec_pulse !== 1'b0 || rollover !== 1'b0 || load_ready !== 1'b0) begin
      failures++; $display("FAIL clr_on_tick got=%h/%b/%b/%b exp=000000/0/0/0", digits, sec_pulse, rollover, load_ready);
    end
    repeat (3) cyc();
    cyc();
    checks++;
    if (sec_pulse !== 1'b1 || digits !== 24'h000001) begin
      failures++; $display("FAIL after_clr got=%b/%h exp=1/000001", sec_pulse, digits);
    end
  endtask

  task automatic test_async_reset();
    repeat (2) cyc();
    reset_n = 1'b0;
    #1;
    checks++;
    if (digits !== 24'h000000 || load_ready !== 1'b1 || sec_pulse !== 1'b0 || load_err !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%h/%b/%b/%b exp=000000/1/0/0", digits, load_ready, sec_pulse, load_err);
    end
    #3;
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++;
      if (digits !== 24'h000000 || sec_pulse !== 1'b0 || load_ready !== 1'b1) begin
        failures++; $display("FAIL post_reset_idle k=%0d got=%h/%b/%b exp=000000/0/1", k, digits, sec_pulse, load_ready);
      end
    end
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();
    cyc();
    checks++;
    if (sec_pulse !== 1'b1 || digits !== 24'h000001) begin
      failures++; $display("FAIL post_reset_start got=%b/%h exp=1/000001", sec_pulse, digits);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_stop_resume();
    test_load_in_run();
    test_load_err();
    test_rollover();
    test_hour_carry();
    test_clr_on_tick();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
